// File: rtl/serial_adder_fsm.sv
// rtl/serial_adder_fsm.sv - bit-serial WIDTH-bit adder driving a one-bit full-adder cell
module full_adder (
    input  logic input_1,
    input  logic input_2,
    input  logic carry_in,
    output logic sum,
    output logic carry_out
);
    assign sum       = input_1 ^ input_2 ^ carry_in;
    assign carry_out = (input_1 & input_2) | (carry_in & (input_1 ^ input_2));
endmodule

module serial_adder_fsm #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_c;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;

    logic             w_fa_sum;
    logic             w_fa_cout;
    logic [WIDTH-1:0] w_s_next;

    full_adder u_fa (
        .input_1   (r_a_sr[0]),
        .input_2   (r_b_sr[0]),
        .carry_in  (r_c),
        .sum       (w_fa_sum),
        .carry_out (w_fa_cout)
    );

    // New sum bit enters at the MSB; after WIDTH shifts the word is aligned.
    assign w_s_next = WIDTH'({w_fa_sum, r_s_sr} >> 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_s_sr  <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_c     <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_c     <= cin;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_s_sr <= w_s_next;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_c    <= w_fa_cout;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_sum   <= w_s_next;
                        r_cout  <= w_fa_cout;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder_fsm.sv
// tb/tb_serial_adder_fsm.sv - directed checks of serial_adder_fsm at WIDTH 8, 3 and 1
module tb_serial_adder_fsm;
    logic       clk = 1'b0;
    logic       rst;
    logic       start8, start3, start1;
    logic [7:0] a8, b8, sum8;
    logic [2:0] a3, b3, sum3;
    logic       a1, b1, sum1;
    logic       cin8, cin3, cin1;
    logic       busy8, busy3, busy1;
    logic       done8, done3, done1;
    logic       cout8, cout3, cout1;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    serial_adder_fsm #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );
    serial_adder_fsm #(.WIDTH(3)) u_w3 (
        .clk(clk), .rst(rst), .start(start3), .a(a3), .b(b3), .cin(cin3),
        .busy(busy3), .done(done3), .sum(sum3), .cout(cout3)
    );
    serial_adder_fsm #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic get_done(input int sel);
        return (sel == 8) ? done8 : (sel == 3) ? done3 : done1;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 8) ? busy8 : (sel == 3) ? busy3 : busy1;
    endfunction

    function automatic logic [8:0] get_result(input int sel);
        return (sel == 8) ? {cout8, sum8} : (sel == 3) ? {5'd0, cout3, sum3} : {7'd0, cout1, sum1};
    endfunction

    task automatic set_start(input int sel, input logic v);
        if (sel == 8) start8 = v;
        else if (sel == 3) start3 = v;
        else start1 = v;
    endtask

    // One addition on the selected instance; returns with that instance back in IDLE.
    task automatic run_op(input int sel, input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic [8:0] exp, input string tag,
                          input bit full);
        int k;
        int nb;
        @(negedge clk);
        if (sel == 8) begin a8 = av; b8 = bv; cin8 = cv; end
        else if (sel == 3) begin a3 = av[2:0]; b3 = bv[2:0]; cin3 = cv; end
        else begin a1 = av[0]; b1 = bv[0]; cin1 = cv; end
        set_start(sel, 1'b1);
        @(negedge clk);
        set_start(sel, 1'b0);
        k  = 0;
        nb = 0;
        while (!get_done(sel) && k < 40) begin
            if (get_busy(sel)) nb++;
            @(negedge clk);
            k++;
        end
        if (full) begin
            check({tag, " latency"}, k, sel);
            check({tag, " busy_cycles"}, nb, sel);
            check({tag, " busy_in_done"}, get_busy(sel), 1'b0);
        end
        check({tag, " result"}, get_result(sel), exp);
        @(negedge clk);
        if (full) check({tag, " done_one_cycle"}, get_done(sel), 1'b0);
    endtask

    initial begin
        int ndone;
        int first_k;
        int second_k;
        int overlap;
        rst = 1'b1;
        start8 = 1'b0; start3 = 1'b0; start1 = 1'b0;
        a8 = '0; b8 = '0; cin8 = 1'b0;
        a3 = '0; b3 = '0; cin3 = 1'b0;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        repeat (2) @(negedge clk);
        check("reset busy", busy8, 1'b0);
        check("reset done", done8, 1'b0);
        check("reset sum", sum8, 8'h00);
        check("reset cout", cout8, 1'b0);
        rst = 1'b0;

        run_op(8, 8'h5A, 8'h33, 1'b0, 9'h08D, "w8 5A+33", 1'b1);
        run_op(8, 8'hFF, 8'h01, 1'b0, 9'h100, "w8 FF+01", 1'b1);
        run_op(8, 8'hFF, 8'hFF, 1'b1, 9'h1FF, "w8 FF+FF+1", 1'b1);

        // Start held for 20 cycles; operands disturbed while each addition is in flight.
        @(negedge clk);
        a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
        ndone = 0; first_k = -1; second_k = -1; overlap = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 2)  begin a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; end
            if (k == 6)  begin a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; end
            if (k == 12) begin a8 = 8'h77; b8 = 8'h77; cin8 = 1'b1; end
            if (busy8 && done8) overlap++;
            if (done8) begin
                ndone++;
                if (ndone == 1) first_k = k; else second_k = k;
                check("held result", {cout8, sum8}, 9'h030);
            end
        end
        start8 = 1'b0;
        check("held done_count", ndone, 2);
        check("held done_spacing", second_k - first_k, 10);
        check("held busy_done_overlap", overlap, 0);
        repeat (2) @(negedge clk);

        // Reset after the third shift edge aborts the addition.
        a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort busy", busy8, 1'b0);
        check("abort sum", sum8, 8'h00);
        check("abort cout", cout8, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done8 || busy8) ndone++;
        end
        check("abort no_done", ndone, 0);
        run_op(8, 8'hAA, 8'h55, 1'b0, 9'h0FF, "w8 AA+55 after abort", 1'b1);

        for (int i = 0; i < 128; i++) begin
            logic [2:0] av;
            logic [2:0] bv;
            logic       cv;
            logic [8:0] exp;
            av  = i[2:0];
            bv  = i[5:3];
            cv  = i[6];
            exp = {5'd0, 4'(av) + 4'(bv) + 4'(cv)};
            run_op(3, {5'd0, av}, {5'd0, bv}, cv, exp, $sformatf("w3 %0d+%0d+%0d", av, bv, cv), (i % 32) == 0);
        end

        run_op(1, 8'h01, 8'h01, 1'b1, 9'h003, "w1 1+1+1", 1'b1);
        run_op(1, 8'h01, 8'h00, 1'b0, 9'h001, "w1 1+0+0", 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
